// File: rtl/register_file_mp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp_pkg
// Description : Shared definitions for the multi-ported register file, its
//               read ports and the decode/writeback stages that slice the
//               flattened port buses.
//                 - idx_width()  : register-index width for a register count
//                 - ZERO_IDX     : index of the hardwired zero register
//                 - rd/wr slice helpers give the LSB of port p in a bus
// Revision    : 1.0 - initial release
// ============================================================================
package register_file_mp_pkg;

  localparam int ZERO_IDX = 0;

  // Width of a register index. Clamped to 1 so a degenerate count still
  // produces a legal vector.
  function automatic int idx_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // LSB of port p in a flattened bus of per-port fields of width w.
  function automatic int port_lsb(input int p, input int w);
    return p * w;
  endfunction

endpackage : register_file_mp_pkg
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : rf_read_port
// Description : One combinational read port of register_file_mp. Selects the
//               addressed register, forwards same-cycle write data when
//               bypass is enabled (highest write port wins), forces index 0
//               to zero when the zero register is enabled, and reports the
//               scoreboard bit with bypass wakeup applied.
// Ports       : rd_reg  - register index to read
//               regs    - current storage contents
//               busy    - current scoreboard vector
//               wr_*    - this cycle's write ports (already reset-gated)
//               rd_data - read data
//               rd_busy - busy bit of the addressed register after wakeup
// Revision    : 1.0 - initial release
// ============================================================================
module rf_read_port
  import register_file_mp_pkg::*;
#(
  parameter int REG_W     = 32,
  parameter int REG_COUNT = 32,
  parameter int WR_PORTS  = 1,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1,
  parameter int IDX_W     = 5
) (
  input  logic [IDX_W-1:0]                   rd_reg,
  input  logic [REG_COUNT-1:0][REG_W-1:0]    regs,
  input  logic [REG_COUNT-1:0]               busy,
  input  logic [WR_PORTS-1:0]                wr_en,
  input  logic [WR_PORTS*IDX_W-1:0]          wr_reg,
  input  logic [WR_PORTS*REG_W-1:0]          wr_data,
  output logic [REG_W-1:0]                   rd_data,
  output logic                               rd_busy
);

  localparam logic [IDX_W-1:0] ZERO_ADDR = IDX_W'(ZERO_IDX);

  logic             hit;
  logic [REG_W-1:0] sel_data;

  always_comb begin
    hit      = 1'b0;
    sel_data = regs[rd_reg];
    if (BYPASS != 0) begin
      // Ascending scan so the highest-numbered matching port is the last
      // assignment and therefore wins.
      for (int w = 0; w < WR_PORTS; w++) begin
        if (wr_en[w] && (wr_reg[port_lsb(w, IDX_W) +: IDX_W] == rd_reg)) begin
          hit      = 1'b1;
          sel_data = wr_data[port_lsb(w, REG_W) +: REG_W];
        end
      end
    end
    rd_busy = busy[rd_reg] & ~hit;
    rd_data = sel_data;
    // Zero register overrides everything, including bypassed data.
    if ((ZERO_REG != 0) && (rd_reg == ZERO_ADDR)) begin
      rd_data = '0;
      rd_busy = 1'b0;
    end
  end

endmodule : rf_read_port
`default_nettype wire

// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module      : register_file_mp
// Description : Parametrised multi-ported register file with RD_PORTS
//               combinational read ports, WR_PORTS synchronous write ports,
//               optional write-to-read bypass, optional hardwired zero
//               register and a per-register busy scoreboard.
// Ports       : clk      - rising-edge clock
//               aresetn  - asynchronous active-low reset
//               rd_reg   - read indices, port p at [p*IDX_W +: IDX_W]
//               rd_data  - read data,    port p at [p*REG_W +: REG_W]
//               rd_busy  - scoreboard bit per read port, after wakeup
//               wr_en    - per-port write enable
//               wr_reg   - write indices
//               wr_data  - write data
//               rsv_en   - reserve a destination register
//               rsv_reg  - register to mark busy
//               busy     - registered scoreboard vector
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int REG_W     = 32,
  parameter int REG_COUNT = 32,
  parameter int RD_PORTS  = 2,
  parameter int WR_PORTS  = 1,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1,
  localparam int IDX_W    = idx_width(REG_COUNT)
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic [RD_PORTS*IDX_W-1:0]   rd_reg,
  output logic [RD_PORTS*REG_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]         rd_busy,
  input  logic [WR_PORTS-1:0]         wr_en,
  input  logic [WR_PORTS*IDX_W-1:0]   wr_reg,
  input  logic [WR_PORTS*REG_W-1:0]   wr_data,
  input  logic                        rsv_en,
  input  logic [IDX_W-1:0]            rsv_reg,
  output logic [REG_COUNT-1:0]        busy
);

  logic [REG_COUNT-1:0][REG_W-1:0] regs_q, regs_d;
  logic [REG_COUNT-1:0]            busy_q, busy_d;
  logic [WR_PORTS-1:0]             wr_en_gated;

  // Keeps bypassed write data off the read ports while reset is held, so
  // every read returns zero during reset.
  assign wr_en_gated = wr_en & {WR_PORTS{aresetn}};

  // --------------------------------------------------------------------------
  // Next state: writes in ascending port order (highest port wins), each
  // write wakes its register, then a reservation re-marks busy so a newly
  // issued producer is not lost to an older writeback in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < WR_PORTS; w++) begin
      if (wr_en[w]) begin
        regs_d[wr_reg[port_lsb(w, IDX_W) +: IDX_W]] = wr_data[port_lsb(w, REG_W) +: REG_W];
        busy_d[wr_reg[port_lsb(w, IDX_W) +: IDX_W]] = 1'b0;
      end
    end
    if (rsv_en) begin
      busy_d[rsv_reg] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      regs_d[ZERO_IDX] = '0;
      busy_d[ZERO_IDX] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd_port
    rf_read_port #(
      .REG_W     (REG_W),
      .REG_COUNT (REG_COUNT),
      .WR_PORTS  (WR_PORTS),
      .BYPASS    (BYPASS),
      .ZERO_REG  (ZERO_REG),
      .IDX_W     (IDX_W)
    ) u_rd_port (
      .rd_reg  (rd_reg[p*IDX_W +: IDX_W]),
      .regs    (regs_q),
      .busy    (busy_q),
      .wr_en   (wr_en_gated),
      .wr_reg  (wr_reg),
      .wr_data (wr_data),
      .rd_data (rd_data[p*REG_W +: REG_W]),
      .rd_busy (rd_busy[p])
    );
  end : g_rd_port

endmodule : register_file_mp
`default_nettype wire
